// File: rtl/rock_pkg.sv
// Shared types and default parameter values for the rocking controller.
package rock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACTIVE    = 2'd1,
      ST_SATURATED = 2'd2,
      ST_FAULT     = 2'd3
   } rock_state_e;

   localparam int unsigned DEF_LVL_W        = 3;
   localparam int unsigned DEF_MAX_LVL      = 7;
   localparam int unsigned DEF_DWELL_TICKS  = 4;
   localparam int unsigned DEF_CALM_WINDOWS = 2;
   localparam int unsigned DEF_GIVEUP_EVALS = 3;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rock_dwell_timer.sv
// Dwell-time limiter: counts slow ticks after each level change and holds
// the most recent evaluation that arrived while the dwell was still running.
module rock_dwell_timer
   import rock_pkg::*;
#(
   parameter int unsigned DWELL_TICKS = DEF_DWELL_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic load_i,
   input  logic tick_i,
   input  logic eval_valid_i,
   input  logic eval_calm_i,
   output logic dwell_zero_o,
   output logic apply_valid_o,
   output logic apply_calm_o
);

   localparam int unsigned     DW_W    = cnt_width(DWELL_TICKS);
   localparam logic [DW_W-1:0] DW_LOAD = DW_W'(DWELL_TICKS);

   logic [DW_W-1:0] dwell_q, dwell_d;
   logic            pend_valid_q, pend_valid_d;
   logic            pend_calm_q, pend_calm_d;

   assign dwell_zero_o  = (dwell_q == '0);
   // A fresh evaluation beats the buffered one when both are ready together.
   assign apply_valid_o = dwell_zero_o && !clr_i && (eval_valid_i || pend_valid_q);
   assign apply_calm_o  = eval_valid_i ? eval_calm_i : pend_calm_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      dwell_d      = dwell_q;
      pend_valid_d = pend_valid_q;
      pend_calm_d  = pend_calm_q;
      if (clr_i) begin
         dwell_d      = '0;
         pend_valid_d = 1'b0;
         pend_calm_d  = 1'b0;
      end else begin
         if (load_i) begin
            dwell_d = DW_LOAD;
         end else if (tick_i && !dwell_zero_o) begin
            dwell_d = dwell_q - 1'b1;
         end
         if (!dwell_zero_o) begin
            if (eval_valid_i) begin
               pend_valid_d = 1'b1;
               pend_calm_d  = eval_calm_i;
            end
         end else begin
            pend_valid_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_calm_q  <= 1'b0;
      end else begin
         dwell_q      <= dwell_d;
         pend_valid_q <= pend_valid_d;
         pend_calm_q  <= pend_calm_d;
      end
   end

endmodule

// File: rtl/rock_controller.sv
// Rocking controller: steps amplitude/frequency levels from stress evaluations.
// Define ROCK_GIVEUP_FAULT_EN to enable the give-up / external-error FAULT state.
module rock_controller
   import rock_pkg::*;
#(
   parameter int unsigned LVL_W        = DEF_LVL_W,
   parameter int unsigned MAX_LVL      = DEF_MAX_LVL,
   parameter int unsigned DWELL_TICKS  = DEF_DWELL_TICKS,
   parameter int unsigned CALM_WINDOWS = DEF_CALM_WINDOWS,
   parameter int unsigned GIVEUP_EVALS = DEF_GIVEUP_EVALS
) (
   input  logic             clk,
   input  logic             extReset,
   input  logic             tick,
   input  logic             evalValid,
   input  logic             stressLaag,
   input  logic             errIn,
   input  logic             clrFault,
   output logic [LVL_W-1:0] amp,
   output logic [LVL_W-1:0] freq,
   output logic             busy,
   output logic             error,
   output logic [1:0]       state
);

   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LVL);
   localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
   localparam int unsigned       CALM_W    = cnt_width(CALM_WINDOWS);
   localparam logic [CALM_W-1:0] CALM_LAST = CALM_W'(CALM_WINDOWS - 1);

   rock_state_e      state_q, state_d;
   logic [LVL_W-1:0] amp_q, amp_d, freq_q, freq_d;
   logic [CALM_W-1:0] calm_q, calm_d;
   logic             busy_q, busy_d;
   logic             load_dwell, apply_valid, apply_calm, dwell_zero;

`ifdef ROCK_GIVEUP_FAULT_EN
   localparam int unsigned       GIVE_W    = cnt_width(GIVEUP_EVALS);
   localparam logic [GIVE_W-1:0] GIVE_LAST = GIVE_W'(GIVEUP_EVALS - 1);
   logic [GIVE_W-1:0] give_q, give_d;
   logic              error_q, error_d;
`else
   logic unused_fault_inputs;
   assign unused_fault_inputs = ^{errIn, clrFault, dwell_zero};
`endif

   rock_dwell_timer #(.DWELL_TICKS(DWELL_TICKS)) u_dwell (
      .clk          (clk),
      .rst_n        (extReset),
      .clr_i        (state_q == ST_FAULT),
      .load_i       (load_dwell),
      .tick_i       (tick),
      .eval_valid_i (evalValid),
      .eval_calm_i  (stressLaag),
      .dwell_zero_o (dwell_zero),
      .apply_valid_o(apply_valid),
      .apply_calm_o (apply_calm)
   );

   always_comb begin
      state_d    = state_q;
      amp_d      = amp_q;
      freq_d     = freq_q;
      calm_d     = calm_q;
      load_dwell = 1'b0;
`ifdef ROCK_GIVEUP_FAULT_EN
      give_d     = give_q;
      if (errIn) begin
         state_d = ST_FAULT;
         amp_d   = '0;
         freq_d  = '0;
         calm_d  = '0;
         give_d  = '0;
      end else if (state_q == ST_FAULT) begin
         amp_d  = '0;
         freq_d = '0;
         if (clrFault) begin
            state_d = ST_IDLE;
            calm_d  = '0;
            give_d  = '0;
         end
      end else
`endif
      if (apply_valid && !apply_calm) begin
         calm_d = '0;
         case (state_q)
            ST_IDLE: begin
               freq_d     = LVL_ONE;
               state_d    = ST_ACTIVE;
               load_dwell = 1'b1;
            end
            ST_ACTIVE: begin
               load_dwell = 1'b1;
               if (freq_q != LVL_MAX) freq_d = freq_q + LVL_ONE;
               else                   amp_d  = amp_q + LVL_ONE;
               if (freq_d == LVL_MAX && amp_d == LVL_MAX) begin
                  state_d = ST_SATURATED;
`ifdef ROCK_GIVEUP_FAULT_EN
                  give_d  = '0;
`endif
               end
            end
            ST_SATURATED: begin
`ifdef ROCK_GIVEUP_FAULT_EN
               if (give_q == GIVE_LAST) begin
                  state_d = ST_FAULT;
                  amp_d   = '0;
                  freq_d  = '0;
                  give_d  = '0;
               end else begin
                  give_d = give_q + 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end else if (apply_valid && state_q != ST_IDLE) begin
         if (calm_q != CALM_LAST) begin
            calm_d = calm_q + 1'b1;
         end else begin
            calm_d     = '0;
            load_dwell = 1'b1;
            if (amp_q != '0)       amp_d  = amp_q - LVL_ONE;
            else if (freq_q != '0) freq_d = freq_q - LVL_ONE;
            state_d = (amp_d == '0 && freq_d == '0) ? ST_IDLE : ST_ACTIVE;
`ifdef ROCK_GIVEUP_FAULT_EN
            give_d  = '0;
`endif
         end
      end
      busy_d = (state_d != ST_IDLE);
`ifdef ROCK_GIVEUP_FAULT_EN
      error_d = (state_d == ST_FAULT);
`endif
   end

   always_ff @(posedge clk) begin
      if (!extReset) begin
         state_q <= ST_IDLE;
         amp_q   <= '0;
         freq_q  <= '0;
         calm_q  <= '0;
         busy_q  <= 1'b0;
`ifdef ROCK_GIVEUP_FAULT_EN
         give_q  <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         amp_q   <= amp_d;
         freq_q  <= freq_d;
         calm_q  <= calm_d;
         busy_q  <= busy_d;
`ifdef ROCK_GIVEUP_FAULT_EN
         give_q  <= give_d;
         error_q <= error_d;
`endif
      end
   end

   assign amp   = amp_q;
   assign freq  = freq_q;
   assign busy  = busy_q;
   assign state = state_q;
`ifdef ROCK_GIVEUP_FAULT_EN
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rock_controller.sv
// Directed testbench for rock_controller at default parameters; expectations
// follow ROCK_GIVEUP_FAULT_EN when it is defined for the build.
module tb_rock_controller;

   logic       clk = 1'b0;
   logic       extReset = 1'b0;
   logic       tick = 1'b0;
   logic       evalValid = 1'b0;
   logic       stressLaag = 1'b0;
   logic       errIn = 1'b0;
   logic       clrFault = 1'b0;
   logic [2:0] amp, freq;
   logic       busy, error;
   logic [1:0] state;

   int pass_cnt = 0;
   int total_cnt = 0;

   rock_controller dut (
      .clk       (clk),
      .extReset  (extReset),
      .tick      (tick),
      .evalValid (evalValid),
      .stressLaag(stressLaag),
      .errIn     (errIn),
      .clrFault  (clrFault),
      .amp       (amp),
      .freq      (freq),
      .busy      (busy),
      .error     (error),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cycle();
         tick = 1'b0;
      end
   endtask

   task automatic send_eval(input logic calm);
      evalValid  = 1'b1;
      stressLaag = calm;
      cycle();
      evalValid  = 1'b0;
      stressLaag = 1'b0;
   endtask

   task automatic reset_dut();
      extReset = 1'b0;
      cycle();
      cycle();
      extReset = 1'b1;
   endtask

   task automatic test_reset();
      reset_dut();
      total_cnt++;
      if ({amp, freq, state, busy, error} !== 10'b0)
         $display("FAIL reset_outputs: got amp=%0d freq=%0d state=%0d busy=%b error=%b, expected all 0",
                  amp, freq, state, busy, error);
      else pass_cnt++;
   endtask

   task automatic test_ramp();
      logic [2:0] exp_a, exp_f;
      logic [1:0] exp_s;
      reset_dut();
      for (int i = 0; i < 14; i++) begin
         send_eval(1'b0);
         exp_f = (i < 7) ? 3'(i + 1) : 3'd7;
         exp_a = (i < 7) ? 3'd0 : 3'(i - 6);
         exp_s = (i == 13) ? 2'd2 : 2'd1;
         total_cnt++;
         if ({amp, freq, state, busy} !== {exp_a, exp_f, exp_s, 1'b1})
            $display("FAIL ramp_step%0d: got amp=%0d freq=%0d state=%0d busy=%b, expected amp=%0d freq=%0d state=%0d busy=1",
                     i, amp, freq, state, busy, exp_a, exp_f, exp_s);
         else pass_cnt++;
         pulse_ticks(4);
      end
   endtask

   // Runs straight after test_ramp: saturated with dwell expired.
   task automatic test_giveup();
      send_eval(1'b0);
      send_eval(1'b0);
      total_cnt++;
      if ({amp, freq, state} !== {3'd7, 3'd7, 2'd2})
         $display("FAIL sat_hold: got amp=%0d freq=%0d state=%0d, expected 7 7 2", amp, freq, state);
      else pass_cnt++;
      send_eval(1'b0);
`ifdef ROCK_GIVEUP_FAULT_EN
      total_cnt++;
      if ({amp, freq, state, error, busy} !== {3'd0, 3'd0, 2'd3, 1'b1, 1'b1})
         $display("FAIL giveup_fault: got amp=%0d freq=%0d state=%0d error=%b busy=%b, expected 0 0 3 1 1",
                  amp, freq, state, error, busy);
      else pass_cnt++;
      errIn = 1'b1; clrFault = 1'b1;
      cycle();
      errIn = 1'b0; clrFault = 1'b0;
      total_cnt++;
      if (state !== 2'd3)
         $display("FAIL err_beats_clr: got state=%0d, expected 3", state);
      else pass_cnt++;
      clrFault = 1'b1;
      cycle();
      clrFault = 1'b0;
      total_cnt++;
      if ({amp, freq, state, error, busy} !== 10'b0)
         $display("FAIL clr_fault: got amp=%0d freq=%0d state=%0d error=%b busy=%b, expected all 0",
                  amp, freq, state, error, busy);
      else pass_cnt++;
`else
      total_cnt++;
      if ({amp, freq, state, error} !== {3'd7, 3'd7, 2'd2, 1'b0})
         $display("FAIL sat_no_giveup: got amp=%0d freq=%0d state=%0d error=%b, expected 7 7 2 0",
                  amp, freq, state, error);
      else pass_cnt++;
`endif
   endtask

   task automatic test_pending_overwrite();
      reset_dut();
      send_eval(1'b0);
      pulse_ticks(1);
      send_eval(1'b0);
      total_cnt++;
      if ({freq, state} !== {3'd1, 2'd1})
         $display("FAIL pend_held: got freq=%0d state=%0d, expected 1 1", freq, state);
      else pass_cnt++;
      pulse_ticks(1);
      send_eval(1'b1);
      pulse_ticks(2);
      cycle();
      total_cnt++;
      if ({amp, freq, state} !== {3'd0, 3'd1, 2'd1})
         $display("FAIL pend_calm_applied: got amp=%0d freq=%0d state=%0d, expected 0 1 1", amp, freq, state);
      else pass_cnt++;
      send_eval(1'b1);
      total_cnt++;
      if ({freq, state, busy} !== {3'd0, 2'd0, 1'b0})
         $display("FAIL pend_calm_counted: got freq=%0d state=%0d busy=%b, expected 0 0 0", freq, state, busy);
      else pass_cnt++;
   endtask

   task automatic test_tick_eval_same_cycle();
      reset_dut();
      send_eval(1'b0);
      pulse_ticks(3);
      tick = 1'b1; evalValid = 1'b1; stressLaag = 1'b0;
      cycle();
      tick = 1'b0; evalValid = 1'b0;
      total_cnt++;
      if (freq !== 3'd1)
         $display("FAIL tick_eval_buffered: got freq=%0d, expected 1", freq);
      else pass_cnt++;
      cycle();
      total_cnt++;
      if (freq !== 3'd2)
         $display("FAIL tick_eval_applied: got freq=%0d, expected 2", freq);
      else pass_cnt++;
   endtask

   task automatic test_new_wins();
      reset_dut();
      send_eval(1'b0);
      pulse_ticks(1);
      send_eval(1'b0);
      pulse_ticks(3);
      send_eval(1'b1);
      cycle();
      total_cnt++;
      if ({freq, state} !== {3'd1, 2'd1})
         $display("FAIL new_wins_drop: got freq=%0d state=%0d, expected 1 1", freq, state);
      else pass_cnt++;
      send_eval(1'b1);
      total_cnt++;
      if ({freq, state} !== {3'd0, 2'd0})
         $display("FAIL new_wins_calm: got freq=%0d state=%0d, expected 0 0", freq, state);
      else pass_cnt++;
   endtask

   task automatic test_step_down();
      logic [2:0] exp_a [4] = '{3'd2, 3'd1, 3'd1, 3'd0};
      reset_dut();
      for (int i = 0; i < 9; i++) begin
         send_eval(1'b0);
         pulse_ticks(4);
      end
      total_cnt++;
      if ({amp, freq} !== {3'd2, 3'd7})
         $display("FAIL down_start: got amp=%0d freq=%0d, expected 2 7", amp, freq);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         send_eval(1'b1);
         total_cnt++;
         if ({amp, freq, state} !== {exp_a[i], 3'd7, 2'd1})
            $display("FAIL down_calm%0d: got amp=%0d freq=%0d state=%0d, expected amp=%0d freq=7 state=1",
                     i, amp, freq, state, exp_a[i]);
         else pass_cnt++;
         pulse_ticks(4);
      end
   endtask

   task automatic test_errin();
      reset_dut();
      send_eval(1'b0);
      errIn = 1'b1;
      cycle();
      errIn = 1'b0;
`ifdef ROCK_GIVEUP_FAULT_EN
      total_cnt++;
      if ({amp, freq, state, error} !== {3'd0, 3'd0, 2'd3, 1'b1})
         $display("FAIL errin_fault: got amp=%0d freq=%0d state=%0d error=%b, expected 0 0 3 1",
                  amp, freq, state, error);
      else pass_cnt++;
      send_eval(1'b0);
      total_cnt++;
      if ({freq, state} !== {3'd0, 2'd3})
         $display("FAIL fault_ignores_eval: got freq=%0d state=%0d, expected 0 3", freq, state);
      else pass_cnt++;
      clrFault = 1'b1;
      cycle();
      clrFault = 1'b0;
      send_eval(1'b0);
      total_cnt++;
      if ({freq, state} !== {3'd1, 2'd1})
         $display("FAIL after_clear_eval: got freq=%0d state=%0d, expected 1 1", freq, state);
      else pass_cnt++;
`else
      total_cnt++;
      if ({freq, state, error} !== {3'd1, 2'd1, 1'b0})
         $display("FAIL errin_ignored: got freq=%0d state=%0d error=%b, expected 1 1 0", freq, state, error);
      else pass_cnt++;
`endif
   endtask

   task automatic test_reset_mid();
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         send_eval(1'b0);
         pulse_ticks(2);
      end
      extReset = 1'b0;
      cycle();
      total_cnt++;
      if ({amp, freq, state, busy, error} !== 10'b0)
         $display("FAIL reset_mid: got amp=%0d freq=%0d state=%0d busy=%b error=%b, expected all 0",
                  amp, freq, state, busy, error);
      else pass_cnt++;
      extReset = 1'b1;
      send_eval(1'b0);
      total_cnt++;
      if ({freq, state} !== {3'd1, 2'd1})
         $display("FAIL reset_clears_dwell: got freq=%0d state=%0d, expected 1 1", freq, state);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_giveup();
      test_pending_overwrite();
      test_tick_eval_same_cycle();
      test_new_wins();
      test_step_down();
      test_errin();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
